// File: rtl/cnn_layer_accel_job_sequencer_if.sv
// Host/quad/loader handshake bundle for the CNN layer job sequencer.
// master = sequencer side, slave = host, quad and loader side.
interface cnn_layer_accel_job_sequencer_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] cmd_params;
    logic         job_start;
    logic         job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request;
    logic         job_fetch_ack;
    logic         fetch_go;
    logic         fetch_done;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack;

    modport master (
        input  cmd_valid, cmd_params, job_accept, job_fetch_request, fetch_done, job_complete,
        output cmd_ready, job_start, job_parameters, job_fetch_ack, fetch_go,
               job_fetch_complete, job_complete_ack
    );

    modport slave (
        output cmd_valid, cmd_params, job_accept, job_fetch_request, fetch_done, job_complete,
        input  cmd_ready, job_start, job_parameters, job_fetch_ack, fetch_go,
               job_fetch_complete, job_complete_ack
    );
endinterface

// File: rtl/cnn_layer_accel_job_sequencer.sv
// CNN layer job sequencer: takes one host descriptor at a time and walks the
// quad through start -> fetch request -> fetch -> completion handshakes.
// Every output is a register; next values are computed in one always_comb.
// Optional watchdog: define CNL_JOB_SEQ_TIMEOUT_EN to abort any non-IDLE
// state that lasts C_TIMEOUT_CYCLES cycles and raise a sticky timeout_err.
module cnn_layer_accel_job_sequencer #(
    parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
    input  logic                                  clk_if,
    input  logic                                  rst,
    cnn_layer_accel_job_sequencer_if.master       bus,
    output logic                                  busy,
    output logic [15:0]                           jobs_done_count,
    output logic                                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_FREQ = 3'd2,
        FETCH     = 3'd3,
        WAIT_CMPL = 3'd4
    } state_t;

    // The watchdog compares against C_TIMEOUT_CYCLES-1, so zero is meaningless.
    if (C_TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("C_TIMEOUT_CYCLES must be at least 1");
    end

    state_t       state_q, state_n;
    logic [127:0] params_q, params_n;
    logic [15:0]  cnt_q, cnt_n;
    logic         rdy_q, rdy_n;
    logic         start_q, start_n;
    logic         fack_q, fack_n;
    logic         go_q, go_n;
    logic         fcmp_q, fcmp_n;
    logic         cack_q, cack_n;
    logic         busy_q;

`ifdef CNL_JOB_SEQ_TIMEOUT_EN
    logic [31:0]  wd_q, wd_n;
    logic         to_q, to_n;
`endif

    // Next state and next registered outputs; every input is only looked at
    // in the state that owns it, so stray pulses elsewhere fall on the floor.
    always_comb begin
        state_n  = state_q;
        params_n = params_q;
        cnt_n    = cnt_q;
        start_n  = 1'b0;
        fack_n   = 1'b0;
        go_n     = 1'b0;
        fcmp_n   = 1'b0;
        cack_n   = 1'b0;
`ifdef CNL_JOB_SEQ_TIMEOUT_EN
        to_n     = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && rdy_q) begin
                    params_n = bus.cmd_params;
                    start_n  = 1'b1;
                    state_n  = START;
                end
            end
            START: begin
                if (bus.job_accept) state_n = WAIT_FREQ;
                else                start_n = 1'b1;
            end
            WAIT_FREQ: begin
                if (bus.job_fetch_request) begin
                    fack_n  = 1'b1;
                    go_n    = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (bus.fetch_done) begin
                    fcmp_n  = 1'b1;
                    state_n = WAIT_CMPL;
                end
            end
            WAIT_CMPL: begin
                if (bus.job_complete) begin
                    cack_n  = 1'b1;
                    cnt_n   = cnt_q + 16'd1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef CNL_JOB_SEQ_TIMEOUT_EN
        // Abort: back to IDLE with every handshake output dropped; the job
        // does not count as done.
        if (state_q != IDLE && wd_q == 32'(C_TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            start_n = 1'b0;
            fack_n  = 1'b0;
            go_n    = 1'b0;
            fcmp_n  = 1'b0;
            cack_n  = 1'b0;
            cnt_n   = cnt_q;
            to_n    = 1'b1;
        end
        wd_n = (state_n != state_q || state_q == IDLE) ? 32'd0 : wd_q + 32'd1;
`endif
        // The completion-ack cycle already sits in IDLE but does not offer
        // cmd_ready; the host sees ready on the very next cycle.
        rdy_n = (state_n == IDLE) && !cack_n;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q  <= IDLE;
            params_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b1;
            start_q  <= 1'b0;
            fack_q   <= 1'b0;
            go_q     <= 1'b0;
            fcmp_q   <= 1'b0;
            cack_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            params_q <= params_n;
            cnt_q    <= cnt_n;
            rdy_q    <= rdy_n;
            start_q  <= start_n;
            fack_q   <= fack_n;
            go_q     <= go_n;
            fcmp_q   <= fcmp_n;
            cack_q   <= cack_n;
            busy_q   <= (state_n != IDLE);
        end
    end

`ifdef CNL_JOB_SEQ_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_n;
            to_q <= to_n;
        end
    end
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    // cmd_ready is held low for as long as rst is asserted; the register
    // itself resets to 1 so ready appears on the first cycle after reset.
    assign bus.cmd_ready          = rdy_q & ~rst;
    assign bus.job_start          = start_q;
    assign bus.job_parameters     = params_q;
    assign bus.job_fetch_ack      = fack_q;
    assign bus.fetch_go           = go_q;
    assign bus.job_fetch_complete = fcmp_q;
    assign bus.job_complete_ack   = cack_q;
    assign busy                   = busy_q;
    assign jobs_done_count        = cnt_q;

endmodule
